// File: rtl/dac_write_arbiter_if.sv
// Bus bundle between the OPP channels / DAC driver and dac_write_arbiter.
// slave = arbiter side, master = surrounding logic (OPP, router, DAC driver).
interface dac_write_arbiter_if #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned W_DATA = 16
);
  logic [N_CHAN*W_DATA-1:0] data_in;
  logic [N_CHAN-1:0]        dv_in;
  logic [N_CHAN-1:0]        active_in;
  logic                     dac_rdy_in;
  logic                     ovr_clr_in;
  logic [31:0]              instr_out;
  logic                     instr_dv_out;
  logic [N_CHAN-1:0]        pending_out;
  logic [N_CHAN-1:0]        overrun_out;

  modport master (
    output data_in, dv_in, active_in, dac_rdy_in, ovr_clr_in,
    input  instr_out, instr_dv_out, pending_out, overrun_out
  );

  modport slave (
    input  data_in, dv_in, active_in, dac_rdy_in, ovr_clr_in,
    output instr_out, instr_dv_out, pending_out, overrun_out
  );
endinterface

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter sharing one serial DAC driver between N_CHAN OPP channels.
// Define DAC_SYNC_UPDATE_EN for input-register-only writes followed by one update-all instruction.
module dac_write_arbiter #(
  parameter int unsigned N_CHAN  = 8,
  parameter int unsigned W_DATA  = 16,
  parameter logic [3:0]  PREFIX  = 4'h0,
  parameter logic [3:0]  FEATURE = 4'h0
) (
  input logic                 clk_in,
  input logic                 reset_in,
  dac_write_arbiter_if.slave  bus
);
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
`ifdef DAC_SYNC_UPDATE_EN
  localparam logic [3:0] CMD_WR = 4'b0000;
`else
  localparam logic [3:0] CMD_WR = 4'b0011;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT} state_e;

  state_e                         state_q, state_d;
  logic [IW-1:0]                  ptr_q, ptr_d;
  logic [IW-1:0]                  grant_q, grant_d;
  logic [N_CHAN-1:0]              pend_q, pend_d;
  logic [N_CHAN-1:0]              ovr_q, ovr_d;
  logic [N_CHAN-1:0][W_DATA-1:0]  buf_q, buf_d;
  logic [31:0]                    instr_q, instr_d;
  logic                           dv_q, dv_d;
  logic                           send_wr_q, send_wr_d;
`ifdef DAC_SYNC_UPDATE_EN
  logic                           upd_q, upd_d;
`endif

  logic          win_found;
  logic [IW-1:0] win_idx;
  int unsigned   idx;

  // First pending channel strictly after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= N_CHAN; k++) begin
      idx = (32'(ptr_q) + k) % N_CHAN;
      if (!win_found && pend_q[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Sample capture, pending and overrun bookkeeping
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    buf_d  = buf_q;
    if (bus.ovr_clr_in) ovr_d = '0;
    if (state_q == S_SEND && send_wr_q) pend_d[grant_q] = 1'b0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      if (!bus.active_in[i]) begin
        pend_d[i] = 1'b0;
      end else if (bus.dv_in[i]) begin
        buf_d[i]  = bus.data_in[i*W_DATA +: W_DATA];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(state_q == S_SEND && send_wr_q && grant_q == IW'(i)))
          ovr_d[i] = 1'b1;
      end
    end
  end

  // Grant / handshake FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    instr_d   = instr_q;
    dv_d      = 1'b0;
    send_wr_d = send_wr_q;
`ifdef DAC_SYNC_UPDATE_EN
    upd_d     = upd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found && bus.dac_rdy_in) begin
          state_d   = S_SEND;
          ptr_d     = win_idx;
          grant_d   = win_idx;
          instr_d   = {PREFIX, CMD_WR, AW'(win_idx), DW'(buf_q[win_idx]), FEATURE};
          dv_d      = 1'b1;
          send_wr_d = 1'b1;
`ifdef DAC_SYNC_UPDATE_EN
          upd_d     = 1'b1;
        end else if (upd_q && bus.dac_rdy_in) begin
          state_d   = S_SEND;
          instr_d   = {PREFIX, 4'b0001, 4'hF, 16'h0000, FEATURE};
          dv_d      = 1'b1;
          send_wr_d = 1'b0;
          upd_d     = 1'b0;
`endif
        end
      end
      S_SEND: state_d = S_HOLD;
      S_HOLD: if (!bus.dac_rdy_in) state_d = S_WAIT;
      S_WAIT: if (bus.dac_rdy_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(N_CHAN - 1);
      grant_q   <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      buf_q     <= '0;
      instr_q   <= '0;
      dv_q      <= 1'b0;
      send_wr_q <= 1'b0;
`ifdef DAC_SYNC_UPDATE_EN
      upd_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      buf_q     <= buf_d;
      instr_q   <= instr_d;
      dv_q      <= dv_d;
      send_wr_q <= send_wr_d;
`ifdef DAC_SYNC_UPDATE_EN
      upd_q     <= upd_d;
`endif
    end
  end

  assign bus.instr_out    = instr_q;
  assign bus.instr_dv_out = dv_q;
  assign bus.pending_out  = pend_q;
  assign bus.overrun_out  = ovr_q;
endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed scoreboard bench for dac_write_arbiter; expected instructions are queued
// as samples are driven and popped by a strobe monitor. Honours DAC_SYNC_UPDATE_EN.
module tb_dac_write_arbiter;
  localparam int unsigned N = 8;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];

  dac_write_arbiter_if #(.N_CHAN(N), .W_DATA(W)) bus ();

  dac_write_arbiter #(.N_CHAN(N), .W_DATA(W), .PREFIX(4'h0), .FEATURE(4'h0)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int ch, input logic [15:0] d);
    logic [3:0] cmd;
`ifdef DAC_SYNC_UPDATE_EN
    cmd = 4'b0000;
`else
    cmd = 4'b0011;
`endif
    return {4'h0, cmd, 4'(ch), d, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every instruction must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.instr_dv_out === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_instr: observed %h expected none", bus.instr_out);
      end
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        assert (bus.instr_out === e) else begin
          miscompares++;
          $error("FAIL instr: observed %h expected %h", bus.instr_out, e);
        end
      end
    end
  end

  task automatic set_ch(input int ch, input logic [15:0] d);
    bus.dv_in[ch] = 1'b1;
    bus.data_in[ch*W +: W] = d;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.dv_in      = '0;
    bus.ovr_clr_in = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = (bus.instr_dv_out === 1'b1);
    end
    vectors++;
    assert (hit) else begin
      miscompares++;
      $error("FAIL %s: strobe observed 0 expected 1 within 40 cycles", tag);
    end
  endtask

  task automatic ack();
    bus.dac_rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.dac_rdy_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic serve(input string tag);
    wait_strobe(tag);
    ack();
  endtask

  task automatic flush_upd();
`ifdef DAC_SYNC_UPDATE_EN
    exp_q.push_back(32'h01F00000);
    serve("update_all");
`endif
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_in    = '0;
    bus.dv_in      = '0;
    bus.active_in  = '1;
    bus.dac_rdy_in = 1'b1;
    bus.ovr_clr_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_strobe",  32'(bus.instr_dv_out), 32'd0);
    chk("rst_instr",   bus.instr_out,         32'd0);
    chk("rst_pending", 32'(bus.pending_out),  32'd0);
    chk("rst_overrun", 32'(bus.overrun_out),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, two-cycle latency, one-cycle strobe
    set_ch(0, 16'd5000);
    exp_q.push_back(mk(0, 16'd5000));
    tick();
    chk("lat_t1_strobe", 32'(bus.instr_dv_out), 32'd0);
    chk("lat_t1_pend",   32'(bus.pending_out),  32'h01);
    @(negedge clk);
    chk("lat_t2_strobe", 32'(bus.instr_dv_out), 32'd1);
    bus.dac_rdy_in = 1'b0;
    @(negedge clk);
    chk("strobe_1cyc", 32'(bus.instr_dv_out), 32'd0);
    chk("pend_clr",    32'(bus.pending_out),  32'd0);
    @(negedge clk);
    bus.dac_rdy_in = 1'b1;
    @(negedge clk);
    flush_upd();

    // Reset in the middle of SEND discards everything
    set_ch(2, 16'h2222);
    set_ch(5, 16'h5555);
    exp_q.push_back(mk(2, 16'h2222));
    tick();
    wait_strobe("pre_reset");
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobe",  32'(bus.instr_dv_out), 32'd0);
    chk("mid_rst_pending", 32'(bus.pending_out),  32'd0);
    chk("mid_rst_overrun", 32'(bus.overrun_out),  32'd0);
    chk("mid_rst_instr",   bus.instr_out,         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin from a fresh pointer: 0,3,7 then 0,7
    set_ch(0, 16'h000A);
    set_ch(3, 16'h001E);
    set_ch(7, 16'h0046);
    exp_q.push_back(mk(0, 16'h000A));
    exp_q.push_back(mk(3, 16'h001E));
    exp_q.push_back(mk(7, 16'h0046));
    tick();
    chk("rr_pend", 32'(bus.pending_out), 32'h89);
    repeat (3) serve("rr_a");
    flush_upd();
    set_ch(0, 16'h0100);
    set_ch(7, 16'h0700);
    exp_q.push_back(mk(0, 16'h0100));
    exp_q.push_back(mk(7, 16'h0700));
    tick();
    repeat (2) serve("rr_b");
    flush_upd();

    // Overrun while the driver is busy; newest sample wins
    bus.dac_rdy_in = 1'b0;
    set_ch(2, 16'd1111);
    tick();
    set_ch(2, 16'd9999);
    tick();
    chk("ovr_set",  32'(bus.overrun_out), 32'h04);
    chk("ovr_pend", 32'(bus.pending_out), 32'h04);
    exp_q.push_back(mk(2, 16'd9999));
    bus.dac_rdy_in = 1'b1;
    serve("ovr_issue");
    flush_upd();
    chk("ovr_pend_clr", 32'(bus.pending_out), 32'd0);
    chk("ovr_sticky",   32'(bus.overrun_out), 32'h04);
    bus.ovr_clr_in = 1'b1;
    tick();
    chk("ovr_clear", 32'(bus.overrun_out), 32'd0);

    // Overrun event beats a same-cycle clear
    bus.dac_rdy_in = 1'b0;
    set_ch(6, 16'h0006);
    tick();
    set_ch(6, 16'h0066);
    bus.ovr_clr_in = 1'b1;
    tick();
    chk("ovr_vs_clr", 32'(bus.overrun_out), 32'h40);
    exp_q.push_back(mk(6, 16'h0066));
    bus.dac_rdy_in = 1'b1;
    serve("ovr_vs_clr_issue");
    flush_upd();
    bus.ovr_clr_in = 1'b1;
    tick();
    chk("ovr_clear2", 32'(bus.overrun_out), 32'd0);

    // Inactive channel ignores dv; deactivation drops a pending sample
    bus.active_in[5] = 1'b0;
    set_ch(5, 16'h0555);
    tick();
    chk("inact_nopend", 32'(bus.pending_out), 32'd0);
    repeat (5) tick();
    bus.dac_rdy_in = 1'b0;
    bus.active_in  = '1;
    set_ch(5, 16'h0555);
    tick();
    chk("act_pend", 32'(bus.pending_out), 32'h20);
    bus.active_in[5] = 1'b0;
    tick();
    chk("deact_clr", 32'(bus.pending_out), 32'd0);
    bus.active_in  = '1;
    bus.dac_rdy_in = 1'b1;
    repeat (6) tick();
    chk("deact_noissue", 32'(exp_q.size()), 32'd0);

    // Two channels in one cycle
    set_ch(1, 16'd1);
    set_ch(4, 16'd2);
    exp_q.push_back(mk(1, 16'd1));
    exp_q.push_back(mk(4, 16'd2));
    tick();
    repeat (2) serve("pair");
    flush_upd();
    repeat (4) tick();

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
